// File: rtl/systolic_tile_ctrl_if.sv
// rtl/systolic_tile_ctrl_if.sv - scheduler/array handshake bundle for the systolic tile sequencer
interface systolic_tile_ctrl_if #(
  parameter int N  = 14,
  parameter int KW = 16,
  parameter int RW = $clog2(N)
);
  // Request side, driven by the BSR scheduler
  logic          start;
  logic [KW-1:0] k_len;
  logic          abort;

  // Array and buffer strobes, driven by the sequencer
  logic          wgt_rd_en;
  logic [RW-1:0] wgt_row;
  logic          load_weight;
  logic          act_rd_en;
  logic [KW-1:0] act_idx;
  logic          en;
  logic          clr;
  logic          busy;
  logic          done;
  logic          res_valid;

  modport master (
    output start, k_len, abort,
    input  wgt_rd_en, wgt_row, load_weight, act_rd_en, act_idx,
           en, clr, busy, done, res_valid
  );

  modport slave (
    input  start, k_len, abort,
    output wgt_rd_en, wgt_row, load_weight, act_rd_en, act_idx,
           en, clr, busy, done, res_valid
  );
endinterface

// File: rtl/systolic_tile_ctrl.sv
// rtl/systolic_tile_ctrl.sv - weight-stationary PE array tile sequencer (load, guard, clear, stream, done)
module systolic_tile_ctrl #(
  parameter int N        = 14,
  parameter int WAIT_CYC = 14,
  parameter int KW       = 16,
  parameter int RW       = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  systolic_tile_ctrl_if.slave bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD_W = 3'd1;
  localparam logic [2:0] S_WAIT_W = 3'd2;
  localparam logic [2:0] S_CLEAR  = 3'd3;
  localparam logic [2:0] S_STREAM = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  // Terminal counts; the stream length adds skew fill and drain (2*(N-1)) to k.
  localparam logic [KW:0] LOAD_LAST = (KW+1)'(N - 1);
  localparam logic [KW:0] WAIT_LAST = (KW+1)'(WAIT_CYC - 1);
  localparam logic [KW:0] SKEW_M1   = (KW+1)'(2 * (N - 1) - 1);

  logic [2:0]    r_state;
  logic [KW:0]   r_cnt;
  logic [KW-1:0] r_k;

  logic          r_wgt_rd_en;
  logic [RW-1:0] r_wgt_row;
  logic          r_load_weight;
  logic          r_act_rd_en;
  logic [KW-1:0] r_act_idx;
  logic          r_en;
  logic          r_clr;
  logic          r_busy;
  logic          r_done;

  logic [2:0]    w_state_nx;
  logic [KW:0]   w_cnt_nx;
  logic [KW-1:0] w_k_nx;
  logic [KW:0]   w_stream_last;
  logic          w_act_nx;

  assign w_stream_last = {1'b0, r_k} + SKEW_M1;

  // Next-state and counter logic; abort overrides everything, including a same-cycle start.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_k_nx     = r_k;
    case (r_state)
      S_IDLE: begin
        if (bus.start && (bus.k_len != '0)) begin
          w_state_nx = S_LOAD_W;
          w_cnt_nx   = '0;
          w_k_nx     = bus.k_len;
        end
      end
      S_LOAD_W: begin
        if (r_cnt == LOAD_LAST) begin
          w_state_nx = S_WAIT_W;
          w_cnt_nx   = '0;
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
      S_WAIT_W: begin
        if (r_cnt == WAIT_LAST) begin
          w_state_nx = S_CLEAR;
          w_cnt_nx   = '0;
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
      S_CLEAR: begin
        w_state_nx = S_STREAM;
        w_cnt_nx   = '0;
      end
      S_STREAM: begin
        if (r_cnt == w_stream_last) begin
          w_state_nx = S_DONE;
          w_cnt_nx   = '0;
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
      S_DONE: begin
        w_state_nx = S_IDLE;
        w_cnt_nx   = '0;
      end
      default: begin
        w_state_nx = S_IDLE;
        w_cnt_nx   = '0;
      end
    endcase
    if (bus.abort) begin
      w_state_nx = S_IDLE;
      w_cnt_nx   = '0;
      w_k_nx     = '0;
    end
  end

  assign w_act_nx = (w_state_nx == S_STREAM) && (w_cnt_nx < {1'b0, w_k_nx});

  // State, counter and latched tile length.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_k     <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_k     <= w_k_nx;
    end
  end

  // Outputs decoded from the next state so every strobe is a flop aligned with its state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wgt_rd_en   <= 1'b0;
      r_wgt_row     <= '0;
      r_load_weight <= 1'b0;
      r_act_rd_en   <= 1'b0;
      r_act_idx     <= '0;
      r_en          <= 1'b0;
      r_clr         <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_load_weight <= (w_state_nx == S_LOAD_W);
      r_wgt_rd_en   <= (w_state_nx == S_LOAD_W);
      r_wgt_row     <= (w_state_nx == S_LOAD_W) ? w_cnt_nx[RW-1:0] : '0;
      r_clr         <= (w_state_nx == S_CLEAR);
      r_en          <= (w_state_nx == S_STREAM);
      r_act_rd_en   <= w_act_nx;
      if (w_act_nx) begin
        r_act_idx <= w_cnt_nx[KW-1:0];
      end else if (w_state_nx != S_STREAM) begin
        r_act_idx <= '0;
      end
      r_busy        <= (w_state_nx != S_IDLE);
      r_done        <= (w_state_nx == S_DONE);
    end
  end

  assign bus.wgt_rd_en   = r_wgt_rd_en;
  assign bus.wgt_row     = r_wgt_row;
  assign bus.load_weight = r_load_weight;
  assign bus.act_rd_en   = r_act_rd_en;
  assign bus.act_idx     = r_act_idx;
  assign bus.en          = r_en;
  assign bus.clr         = r_clr;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.res_valid   = r_done;

  // Weight load, clear, MAC enable and completion are mutually exclusive.
  a_strobe_excl: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0({r_load_weight, r_clr, r_en, r_done}));

endmodule

// File: tb/tb_systolic_tile_ctrl.sv
// tb/tb_systolic_tile_ctrl.sv - randomized and directed check of the tile sequencer against a timeline model
module tb_systolic_tile_ctrl;

  localparam int N        = 14;
  localparam int WAIT_CYC = 14;
  localparam int KW       = 16;
  localparam int RW       = $clog2(N);

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  systolic_tile_ctrl_if #(.N(N), .KW(KW), .RW(RW)) bus();

  systolic_tile_ctrl #(.N(N), .WAIT_CYC(WAIT_CYC), .KW(KW), .RW(RW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  // Tile timeline model: a tile accepted in cycle t0 is described purely by offsets from t0.
  bit m_active = 1'b0;
  int m_t0     = 0;
  int m_k      = 0;

  int en_cnt   = 0;
  int act_cnt  = 0;
  int done_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
  endtask

  function automatic int done_off(input int k);
    return N + WAIT_CYC + 1 + k + 2 * (N - 1) + 1;
  endfunction

  task automatic check_outputs();
    int t, s0;
    logic e_load, e_clr, e_en, e_act, e_busy, e_done;
    int e_row, e_idx;
    e_load = 0; e_clr = 0; e_en = 0; e_act = 0; e_busy = 0; e_done = 0;
    e_row = 0; e_idx = 0;
    if (m_active) begin
      t  = cyc - m_t0;
      s0 = N + WAIT_CYC + 2;
      e_busy = 1;
      if (t >= 1 && t <= N) begin
        e_load = 1;
        e_row  = t - 1;
      end
      if (t == N + WAIT_CYC + 1) e_clr = 1;
      if (t >= s0 && t < s0 + m_k + 2 * (N - 1)) begin
        e_en = 1;
        if (t < s0 + m_k) begin
          e_act = 1;
          e_idx = t - s0;
        end else begin
          e_idx = m_k - 1;
        end
      end
      if (t == done_off(m_k)) e_done = 1;
    end
    chk("load_weight", 32'(bus.load_weight), 32'(e_load));
    chk("wgt_rd_en",   32'(bus.wgt_rd_en),   32'(e_load));
    chk("wgt_row",     32'(bus.wgt_row),     32'(e_row));
    chk("clr",         32'(bus.clr),         32'(e_clr));
    chk("en",          32'(bus.en),          32'(e_en));
    chk("act_rd_en",   32'(bus.act_rd_en),   32'(e_act));
    chk("act_idx",     32'(bus.act_idx),     32'(e_idx));
    chk("busy",        32'(bus.busy),        32'(e_busy));
    chk("done",        32'(bus.done),        32'(e_done));
    chk("res_valid",   32'(bus.res_valid),   32'(e_done));
    en_cnt   += int'(bus.en);
    act_cnt  += int'(bus.act_rd_en);
    done_cnt += int'(bus.done);
  endtask

  // Drive one cycle of inputs, advance the model, then check the following cycle.
  task automatic step(input logic s, input logic [KW-1:0] k, input logic a);
    bit cur, last;
    bus.start = s;
    bus.k_len = k;
    bus.abort = a;
    cur  = m_active;
    last = cur && ((cyc - m_t0) == done_off(m_k));
    if (a) begin
      m_active = 0;
    end else if (!cur) begin
      if (s && (k != 0)) begin
        m_active = 1;
        m_t0     = cyc;
        m_k      = int'(k);
      end
    end else if (last) begin
      m_active = 0;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, KW'($urandom), 1'b0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.k_len = '0;
    bus.abort = 1'b0;

    // Reset state
    repeat (3) begin
      @(negedge clk);
      check_outputs();
    end
    rst_n = 1'b1;
    check_outputs();

    // Reference tile, k_len=3
    step(1'b1, 16'd3, 1'b0);
    en_cnt = 0; act_cnt = 0; done_cnt = 0;
    idle(64);
    chk("k3_en_cycles", 32'(en_cnt), 32'd29);
    chk("k3_act_cycles", 32'(act_cnt), 32'd3);
    chk("k3_done_pulses", 32'(done_cnt), 32'd1);

    // Zero-length starts are ignored
    for (int i = 0; i < 50; i++) step(1'b1, 16'd0, 1'b0);
    idle(2);

    // Continuous start with k_len=1: back-to-back tiles with a one-cycle IDLE gap
    for (int i = 0; i < 130; i++) step(1'b1, 16'd1, 1'b0);
    idle(70);

    // Abort at offset 35, restart at offset 40
    for (int i = 0; i <= 40; i++) step(i == 0 || i == 40, 16'd3, i == 35);
    idle(70);

    // Abort and start together in IDLE: abort wins
    step(1'b1, 16'd4, 1'b1);
    idle(3);

    // Live k_len change during STREAM of a k_len=5 tile
    step(1'b1, 16'd5, 1'b0);
    en_cnt = 0; act_cnt = 0; done_cnt = 0;
    for (int i = 1; i < 70; i++) step(1'b0, (i >= 30) ? 16'd100 : 16'd5, 1'b0);
    chk("k5_en_cycles", 32'(en_cnt), 32'd31);
    chk("k5_act_cycles", 32'(act_cnt), 32'd5);
    chk("k5_done_pulses", 32'(done_cnt), 32'd1);

    // Asynchronous reset while loading row 6
    step(1'b1, 16'd3, 1'b0);
    for (int i = 1; i < 7; i++) step(1'b0, 16'd3, 1'b0);
    chk("row_before_reset", 32'(bus.wgt_row), 32'd6);
    done_cnt = 0;
    rst_n = 1'b0;
    m_active = 0;
    #1;
    check_outputs();
    repeat (2) begin
      @(negedge clk);
      cyc++;
      check_outputs();
    end
    rst_n = 1'b1;
    idle(60);
    chk("no_done_after_reset", 32'(done_cnt), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic s, a;
      logic [KW-1:0] k;
      s = ($urandom_range(0, 3) == 0);
      a = ($urandom_range(0, 149) == 0);
      k = ($urandom_range(0, 9) == 0) ? 16'd0 : KW'($urandom_range(1, 6));
      step(s, k, a);
    end
    idle(80);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
